// File: rtl/scan_display_pkg.sv
// Shared definitions for the multiplexed display scanner: FSM state
// encoding and the width helper used to size the scan index and counters.
package scan_display_pkg;

    // BLANK is the reset state so the scanner always starts dark.
    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    // Number of bits needed to encode values 0..value-1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/scan_display_lz_mask.sv
// Leading-zero suppression mask. A digit is blanked when suppression is
// on and it and every more-significant nibble are zero. Digit 0 always
// stays visible so a value of zero still shows a single "0".
module lz_mask
    import scan_display_pkg::*;
#(
    parameter int NUM_DIGITS = 8
) (
    input  logic [4*NUM_DIGITS-1:0] shadow,
    input  logic                    lz_suppress,
    output logic [NUM_DIGITS-1:0]   mask
);

    // zero_above[i] is set when nibbles i..NUM_DIGITS-1 are all zero.
    logic [NUM_DIGITS-1:0] zero_above;

    // Ripple the all-zero condition down from the top digit, then gate it.
    always_comb begin
        zero_above = '0;
        mask       = '0;
        zero_above[NUM_DIGITS-1] = (shadow[4*NUM_DIGITS-1 -: 4] == 4'h0);
        for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
            zero_above[i] = zero_above[i+1] && (shadow[4*i +: 4] == 4'h0);
        end
        for (int i = 1; i < NUM_DIGITS; i++) begin
            mask[i] = lz_suppress && zero_above[i];
        end
    end

endmodule

// File: rtl/scan_display_ctrl.sv
// Multiplexed seven-segment scan controller. Each digit is lit for DIV
// clocks followed by BLANK_CYC all-dark clocks to prevent ghosting. The
// displayed nibbles come from a shadow register captured once per frame
// (or on demand via load) so a frame never shows a torn value.
module scan_display_ctrl
    import scan_display_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int DIV        = 100000,
    parameter int BLANK_CYC  = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [4*NUM_DIGITS-1:0]      data,
    input  logic [NUM_DIGITS-1:0]        digit_en,
    input  logic                         lz_suppress,
    input  logic                         load,
    output logic [NUM_DIGITS-1:0]        anode,
    output logic [3:0]                   nib,
    output logic [clog2(NUM_DIGITS)-1:0] sel,
    output logic                         frame_done
);

    localparam int SEL_W  = clog2(NUM_DIGITS);
    // +1 keeps the counters at least one bit wide for the minimum parameters.
    localparam int PSC_W  = clog2(DIV + 1);
    localparam int BCNT_W = clog2(BLANK_CYC + 1);

    localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(NUM_DIGITS - 1);
    localparam logic [PSC_W-1:0]  PSC_LAST  = PSC_W'(DIV - 1);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BLANK_CYC - 1);

    scan_state_t             state_q, state_d;
    logic [PSC_W-1:0]        psc_q, psc_d;
    logic [BCNT_W-1:0]       bcnt_q, bcnt_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic                    wrap;
    logic [4*NUM_DIGITS-1:0] shadow_q;
    logic [NUM_DIGITS-1:0]   supp_mask;
    logic                    lit;
    logic [NUM_DIGITS-1:0]   anode_d, anode_p1;
    logic [3:0]              nib_d, nib_p1;
    logic                    frame_done_p1;

    lz_mask #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_lz_mask (
        .shadow      (shadow_q),
        .lz_suppress (lz_suppress),
        .mask        (supp_mask)
    );

    // FSM state, prescaler, blanking counter and scan index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= BLANK;
            psc_q   <= '0;
            bcnt_q  <= '0;
            sel_q   <= SEL_LAST;
        end else begin
            state_q <= state_d;
            psc_q   <= psc_d;
            bcnt_q  <= bcnt_d;
            sel_q   <= sel_d;
        end
    end

    // Next-state logic: SHOW for DIV clocks, BLANK for BLANK_CYC clocks,
    // advancing the scan index as each blanking interval ends.
    always_comb begin
        state_d = state_q;
        psc_d   = psc_q;
        bcnt_d  = bcnt_q;
        sel_d   = sel_q;
        wrap    = 1'b0;
        case (state_q)
            SHOW: begin
                if (psc_q == PSC_LAST) begin
                    bcnt_d  = '0;
                    state_d = BLANK;
                end else begin
                    psc_d = psc_q + 1'b1;
                end
            end
            BLANK: begin
                if (bcnt_q == BCNT_LAST) begin
                    psc_d   = '0;
                    state_d = SHOW;
                    if (sel_q == SEL_LAST) begin
                        sel_d = '0;
                        wrap  = 1'b1;
                    end else begin
                        sel_d = sel_q + 1'b1;
                    end
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
        endcase
    end

    // Shadow capture at the start of each frame or on an explicit load;
    // both together are still just one capture of the current data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_q <= '0;
        end else if (wrap || load) begin
            shadow_q <= data;
        end
    end

    // Decode the drive for the current slot: only a SHOW slot whose digit
    // is enabled and not suppressed pulls its anode low.
    always_comb begin
        anode_d = '1;
        nib_d   = 4'h0;
        lit     = 1'b0;
        if (state_q == SHOW) begin
            nib_d = shadow_q[{sel_q, 2'b00} +: 4];
            lit   = digit_en[sel_q] && !supp_mask[sel_q];
            if (lit) begin
                anode_d[sel_q] = 1'b0;
            end
        end
    end

    // Output stage: registered drive, one clock behind the FSM. The async
    // reset darkens the display immediately, mid-slot included.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            anode_p1      <= '1;
            nib_p1        <= 4'h0;
            frame_done_p1 <= 1'b0;
        end else begin
            anode_p1      <= anode_d;
            nib_p1        <= nib_d;
            frame_done_p1 <= wrap;
        end
    end

    assign anode      = anode_p1;
    assign nib        = nib_p1;
    assign frame_done = frame_done_p1;
    assign sel        = sel_q;

endmodule
